// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame, ack check.
// Optional watchdog on the whole transfer: define PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INHIBIT = 3'd1;
  localparam logic [2:0] S_RTS     = 3'd2;
  localparam logic [2:0] S_SHIFT   = 3'd3;
  localparam logic [2:0] S_ACK     = 3'd4;
  localparam logic [2:0] S_WAIT    = 3'd5;

  logic [2:0]    state;
  logic          clk_s1;
  logic          clk_s2;
  logic          clk_s3;
  logic          data_s1;
  logic          data_s2;
  logic          fall;
  logic [IW-1:0] inh_cnt;
  logic [3:0]    edge_cnt;
  logic [7:0]    shreg;
  logic          parity;
  logic          wd_hit;

  assign fall     = clk_s3 & ~clk_s2;
  assign tx_ready = (state == S_IDLE) & ~rst;

  // Two-flop synchronizers plus a third clock stage for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      clk_s3  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk_in;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      data_s1 <= ps2_data_in;
      data_s2 <= data_s1;
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wd_cnt;

  // Watchdog counts from the accept edge while any transfer is active.
  always_ff @(posedge clk) begin
    if (rst || state == S_IDLE) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign wd_hit = (state != S_IDLE) &&
                  (wd_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  // No watchdog; the parameter is only referenced so it stays in the interface.
  assign wd_hit = (TIMEOUT_CYCLES < 0);
`endif

  // Transfer sequencer driving the open-drain enables and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
      inh_cnt     <= '0;
      edge_cnt    <= '0;
      shreg       <= '0;
      parity      <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      if (wd_hit) begin
        state       <= S_IDLE;
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        tx_err      <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (tx_valid) begin
              shreg       <= tx_data;
              parity      <= ~^tx_data;
              inh_cnt     <= '0;
              ps2_clk_oe  <= 1'b1;
              ps2_data_oe <= 1'b0;
              state       <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
              ps2_clk_oe  <= 1'b0;
              ps2_data_oe <= 1'b1;
              state       <= S_RTS;
            end else begin
              inh_cnt <= inh_cnt + 1'b1;
            end
          end
          S_RTS: begin
            edge_cnt <= '0;
            state    <= S_SHIFT;
          end
          S_SHIFT: begin
            if (fall) begin
              edge_cnt <= edge_cnt + 1'b1;
              if (edge_cnt < 4'd8) begin
                ps2_data_oe <= ~shreg[edge_cnt[2:0]];
              end else if (edge_cnt == 4'd8) begin
                ps2_data_oe <= ~parity;
              end else begin
                ps2_data_oe <= 1'b0;
                state       <= S_ACK;
              end
            end
          end
          S_ACK: begin
            if (fall) begin
              if (data_s2) begin
                tx_err <= 1'b1;
                state  <= S_IDLE;
              end else begin
                state <= S_WAIT;
              end
            end
          end
          S_WAIT: begin
            if (clk_s2 && data_s2) begin
              tx_done <= 1'b1;
              state   <= S_IDLE;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
